seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_pkg.sv | 18 +
 rtl/seg7_glyph.sv | 11 +
 rtl/seg7_scan.sv | 139 +++++++++++++
 tb/tb_seg7_scan.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seg7 definitions: radix modes, the blank pattern and the active-low glyph table.
package seg7_pkg;

  typedef enum logic [1:0] {
    SEG7_BIN = 2'd0,
    SEG7_OCT = 2'd1,
    SEG7_HEX = 2'd2
  } seg7_mode_t;

  localparam logic [6:0] SEG7_DISP_BLANK = 7'h7F;

  // Active-low, bit 0 = segment a; entry n is the glyph for value n (listed F down to 0).
  localparam logic [15:0][6:0] SEG7_GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_glyph.sv
// Maps one 4-bit digit value to its active-low 7-segment pattern.
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] pattern
);

  assign pattern = SEG7_GLYPHS[digit];

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed 7-segment scanner: double-buffered display word, radix decode,
// leading-zero blanking and per-slot PWM brightness.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  input  seg7_mode_t              load_mode,
  input  logic                    lz_blank,
  input  logic [3:0]              brightness,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_en
);

  localparam int VW = 4 * NUM_DIGITS;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [15:0]   PRESC_LAST = 16'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [15:0]     presc;
  logic [IW-1:0]   idx;
  logic            wrap, frame_end, accept;

  logic            pend, pend_lz, disp_lz;
  logic [VW-1:0]   pend_val, disp_val;
  seg7_mode_t      pend_mode, disp_mode;

  logic [VW-1:0]   sh;
  logic [3:0]      dig, sel_digit;
  logic            seen, sel_blank;
  logic [NUM_DIGITS-1:0] onehot;
  logic [19:0]     on_thresh;
  logic            lit;
  logic [6:0]      glyph;

  assign wrap      = (presc == PRESC_LAST);
  assign frame_end = wrap && (idx == IDX_LAST);

  // Load handshake: a word transfers on any rising edge where load_valid and
  // load_ready are both high. load_ready is simply "no word pending", so it
  // drops the cycle after a transfer and rises the cycle after the frame-end apply.
  assign load_ready = !pend;
  assign accept     = load_valid && load_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (wrap) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= 1'b0;
      pend_val  <= '0;
      pend_mode <= SEG7_HEX;
      pend_lz   <= 1'b0;
      disp_val  <= '0;
      disp_mode <= SEG7_HEX;
      disp_lz   <= 1'b0;
    end else if (frame_end && pend) begin
      disp_val  <= pend_val;
      disp_mode <= pend_mode;
      disp_lz   <= pend_lz;
      pend      <= 1'b0;
    end else if (accept) begin
      pend_val  <= load_val;
      pend_mode <= load_mode;
      pend_lz   <= lz_blank;
      pend      <= 1'b1;
    end
  end

  // Walk digits from the top so "seen" marks any nonzero digit at or above d;
  // shifting past the word width naturally yields zero digits.
  always_comb begin
    sh        = '0;
    dig       = '0;
    seen      = 1'b0;
    sel_digit = '0;
    sel_blank = 1'b0;
    onehot    = '0;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      case (disp_mode)
        SEG7_HEX: begin
          sh  = disp_val >> (4 * d);
          dig = sh[3:0];
        end
        SEG7_OCT: begin
          sh  = disp_val >> (3 * d);
          dig = {1'b0, sh[2:0]};
        end
        default: begin
          sh  = disp_val >> d;
          dig = {3'b000, sh[0]};
        end
      endcase
      seen = seen | (dig != 4'd0);
      if (idx == IW'(d)) begin
        sel_digit = dig;
        sel_blank = disp_lz && !seen && (d != 0);
        onehot[d] = 1'b1;
      end
    end
  end

  assign on_thresh = ((20'(brightness) + 20'd1) * 20'(CLK_DIV)) >> 4;
  assign lit       = ({4'b0000, presc} < on_thresh);

  seg7_glyph u_glyph (
    .digit   (sel_digit),
    .pattern (glyph)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg    <= SEG7_DISP_BLANK;
      dig_en <= '0;
    end else if (lit) begin
      seg    <= sel_blank ? SEG7_DISP_BLANK : glyph;
      dig_en <= onehot;
    end else begin
      seg    <= SEG7_DISP_BLANK;
      dig_en <= '0;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: time-based reference model checked every cycle, directed
// digit captures with literal glyphs, PWM count, async reset and random traffic.
module tb_seg7_scan;
  import seg7_pkg::*;

  localparam int N     = 4;
  localparam int CLK   = 16;
  localparam int FRAME = N * CLK;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_val;
  seg7_mode_t  load_mode;
  logic        lz_blank;
  logic [3:0]  brightness;
  logic [6:0]  seg;
  logic [3:0]  dig_en;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_on      = 1'b0;

  always #5 clk = ~clk;

  seg7_scan #(.NUM_DIGITS(N), .CLK_DIV(CLK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_val   (load_val),
    .load_mode  (load_mode),
    .lz_blank   (lz_blank),
    .brightness (brightness),
    .seg        (seg),
    .dig_en     (dig_en)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [6:0] glyph(input int d);
    logic [6:0] hi;
    case (d)
      0: hi = 7'h3F;  1: hi = 7'h06;  2: hi = 7'h5B;  3: hi = 7'h4F;
      4: hi = 7'h66;  5: hi = 7'h6D;  6: hi = 7'h7D;  7: hi = 7'h07;
      8: hi = 7'h7F;  9: hi = 7'h6F;  10: hi = 7'h77; 11: hi = 7'h7C;
      12: hi = 7'h39; 13: hi = 7'h5E; 14: hi = 7'h79; default: hi = 7'h71;
    endcase
    return ~hi;
  endfunction

  function automatic int digit_of(input int v, input seg7_mode_t m, input int i);
    case (m)
      SEG7_HEX: return (v >> (4 * i)) & 15;
      SEG7_OCT: return (v >> (3 * i)) & 7;
      default:  return (v >> i) & 1;
    endcase
  endfunction

  // Returns {dig_en, seg} for a display state at cycle tt after reset release.
  function automatic logic [10:0] model_out(input int tt, input int v, input seg7_mode_t m,
                                            input logic lz, input int b);
    int i, p, msd, d;
    logic [6:0] s;
    logic [3:0] e;
    i = (tt / CLK) % N;
    p = tt % CLK;
    s = 7'h7F;
    e = 4'b0000;
    if (p < (((b + 1) * CLK) >> 4)) begin
      e   = 4'(1 << i);
      msd = 0;
      for (int k = 0; k < N; k++) if (digit_of(v, m, k) != 0) msd = k;
      d = digit_of(v, m, i);
      s = (lz && i > msd) ? 7'h7F : glyph(d);
    end
    return {e, s};
  endfunction

  int          t;
  logic [15:0] m_val, p_val;
  seg7_mode_t  m_mode, p_mode;
  logic        m_lz, p_lz, m_pend;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_en;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t       <= 0;
      m_val   <= '0;
      m_mode  <= SEG7_HEX;
      m_lz    <= 1'b0;
      p_val   <= '0;
      p_mode  <= SEG7_HEX;
      p_lz    <= 1'b0;
      m_pend  <= 1'b0;
      exp_seg <= 7'h7F;
      exp_en  <= 4'b0000;
    end else begin
      {exp_en, exp_seg} <= model_out(t, int'(m_val), m_mode, m_lz, int'(brightness));
      if ((t % FRAME) == FRAME - 1 && m_pend) begin
        m_val  <= p_val;
        m_mode <= p_mode;
        m_lz   <= p_lz;
        m_pend <= 1'b0;
      end else if (load_valid && !m_pend) begin
        p_val  <= load_val;
        p_mode <= load_mode;
        p_lz   <= lz_blank;
        m_pend <= 1'b1;
      end
      t <= t + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("seg", 32'(seg), 32'(exp_seg));
      check("dig_en", 32'(dig_en), 32'(exp_en));
      check("load_ready", 32'(load_ready), 32'(!m_pend));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int k = 0;
    while (load_ready !== 1'b1 && k < 500) begin
      @(posedge clk); #2;
      k++;
    end
    if (load_ready !== 1'b1) check("ready_timeout", 32'(load_ready), 32'd1);
  endtask

  task automatic load_word(input logic [15:0] v, input seg7_mode_t m, input logic lz);
    wait_ready();
    load_val   = v;
    load_mode  = m;
    lz_blank   = lz;
    load_valid = 1'b1;
    @(posedge clk); #2;
    load_valid = 1'b0;
  endtask

  // Waits for the pending word to be applied, then samples each digit slot at prescaler 0.
  task automatic capture(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                         input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] ex [4];
    ex = '{e0, e1, e2, e3};
    wait_ready();
    @(posedge clk); #3;
    for (int d = 0; d < 4; d++) begin
      if (d > 0) begin
        repeat (16) @(posedge clk);
        #3;
      end
      check({tag, "_seg"}, 32'(seg), 32'(ex[d]));
      check({tag, "_en"}, 32'(dig_en), 32'(1 << d));
    end
  endtask

  initial begin
    int cnt;
    load_valid = 1'b0;
    load_val   = '0;
    load_mode  = SEG7_HEX;
    lz_blank   = 1'b0;
    brightness = 4'd15;
    rst_n      = 1'b1;
    #1 rst_n   = 1'b0;
    chk_on     = 1'b1;
    #1;
    check("reset_seg", 32'(seg), 32'h7F);
    check("reset_en", 32'(dig_en), 32'd0);
    check("reset_ready", 32'(load_ready), 32'd1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    load_word(16'h12AF, SEG7_HEX, 1'b0);
    capture("hex12af", 7'h0E, 7'h08, 7'h24, 7'h79);

    repeat (20) @(posedge clk);
    #2;
    load_word(16'h3456, SEG7_HEX, 1'b0);
    check("ready_low_pending", 32'(load_ready), 32'd0);
    load_val   = 16'hBEEF;
    load_valid = 1'b1;
    repeat (5) @(posedge clk);
    #2 load_valid = 1'b0;
    capture("hex3456", 7'h02, 7'h12, 7'h19, 7'h30);

    load_word(16'h0050, SEG7_HEX, 1'b1);
    capture("lz0050", 7'h40, 7'h12, 7'h7F, 7'h7F);

    load_word(16'h0000, SEG7_HEX, 1'b1);
    capture("lzzero", 7'h40, 7'h7F, 7'h7F, 7'h7F);

    load_word(16'h000A, SEG7_BIN, 1'b0);
    capture("bin1010", 7'h40, 7'h79, 7'h40, 7'h79);

    load_word(16'o7, SEG7_OCT, 1'b0);
    capture("oct7", 7'h78, 7'h40, 7'h40, 7'h40);

    brightness = 4'd3;
    cnt = 0;
    repeat (FRAME) begin
      @(negedge clk);
      if (dig_en != 4'b0000) cnt++;
    end
    check("pwm_b3_on_cycles", 32'(cnt), 32'd16);
    brightness = 4'd15;

    load_word(16'h9999, SEG7_HEX, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_seg", 32'(seg), 32'h7F);
    check("async_rst_en", 32'(dig_en), 32'd0);
    check("async_rst_ready", 32'(load_ready), 32'd1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #3;
    check("restart_seg", 32'(seg), 32'h40);
    check("restart_en", 32'(dig_en), 32'd1);
    repeat (FRAME + 8) @(posedge clk);
    #2;

    for (int c = 0; c < 3000; c++) begin
      load_valid = ($urandom_range(0, 3) == 0);
      load_val   = 16'($urandom);
      load_mode  = seg7_mode_t'($urandom_range(0, 2));
      lz_blank   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) brightness = 4'($urandom_range(0, 15));
      @(posedge clk); #2;
    end
    load_valid = 1'b0;
    repeat (5) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
